// File: rtl/wb_trace_fifo_if.sv
// Write-back capture stream in, trace handshake and status out.
interface wb_trace_fifo_if #(
  parameter int unsigned CW = 4
);
  logic          wb_en;
  logic [31:0]   wb_pc;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          clr;
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_pc;
  logic [4:0]    trace_addr;
  logic [31:0]   trace_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  // Core/checker side: drives retiring writes and consumes the trace.
  modport master (
    output wb_en, wb_pc, wb_addr, wb_data, clr, trace_ready,
    input  trace_valid, trace_pc, trace_addr, trace_data, count, overflow, drop_cnt
  );

  // Trace buffer side.
  modport slave (
    input  wb_en, wb_pc, wb_addr, wb_data, clr, trace_ready,
    output trace_valid, trace_pc, trace_addr, trace_data, count, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Show-ahead trace FIFO for retired register-file writes, with drop accounting.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  wb_trace_fifo_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          valid_q, valid_d;
  entry_t        head_q, head_d;

  logic   capture_c, pop_c, full_c, push_c, drop_c;
  entry_t in_entry_c;

  // Event qualification; clr suppresses both push and drop accounting.
  assign in_entry_c = {bus.wb_pc, bus.wb_addr, bus.wb_data};
  assign capture_c  = bus.wb_en && (bus.wb_addr != 5'd0);
  assign pop_c      = valid_q && bus.trace_ready;
  assign full_c     = (count_q == CW'(DEPTH));
  assign push_c     = !bus.clr && capture_c && (!full_c || pop_c);
  assign drop_c     = !bus.clr && capture_c && full_c && !pop_c;

  // Next-state for pointers, occupancy, drop status and the registered head.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    valid_d    = 1'b0;
    head_d     = '0;
    if (bus.clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop_c) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      // Head register mirrors the entry at the new read pointer; when that slot
      // is being written this edge, take the incoming event directly.
      if (count_d != '0) begin
        valid_d = 1'b1;
        head_d  = (push_c && (wr_ptr_q == rd_ptr_d)) ? in_entry_c : mem_q[rd_ptr_d];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= in_entry_c;
  end

  assign bus.trace_valid = valid_q;
  assign bus.trace_pc    = head_q.pc;
  assign bus.trace_addr  = head_q.addr;
  assign bus.trace_data  = head_q.data;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   fails;

  wb_trace_fifo_if #(.CW(CW)) bus_if ();

  wb_trace_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents in capture order plus drop bookkeeping.
  logic [68:0] mq[$];
  logic        m_ovf;
  int          m_drop;

  function automatic logic [31:0] exp_data();
    logic [68:0] e;
    if (mq.size() == 0) return 32'd0;
    e = mq[0];
    return e[31:0];
  endfunction

  function automatic logic [31:0] exp_pc();
    logic [68:0] e;
    if (mq.size() == 0) return 32'd0;
    e = mq[0];
    return e[68:37];
  endfunction

  function automatic logic [4:0] exp_addr();
    logic [68:0] e;
    if (mq.size() == 0) return 5'd0;
    e = mq[0];
    return e[36:32];
  endfunction

  task automatic drive(input logic en, input logic [4:0] addr, input logic [31:0] pc,
                       input logic [31:0] data, input logic rdy, input logic c);
    bus_if.wb_en       = en;
    bus_if.wb_addr     = addr;
    bus_if.wb_pc       = pc;
    bus_if.wb_data     = data;
    bus_if.trace_ready = rdy;
    bus_if.clr         = c;
  endtask

  // Apply the model rules for the upcoming edge, then advance to just after it.
  task automatic tick();
    logic pop;
    logic cap;
    pop = (mq.size() > 0) && bus_if.trace_ready;
    cap = bus_if.wb_en && (bus_if.wb_addr != 5'd0);
    if (bus_if.clr) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back({bus_if.wb_pc, bus_if.wb_addr, bus_if.wb_data});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus_if.trace_valid !== 1'b0 || bus_if.count !== 4'd0) begin
      fails++; $display("FAIL reset_valid_count: valid=%0b count=%0d want 0/0", bus_if.trace_valid, bus_if.count);
    end
    tests_run++;
    if (bus_if.overflow !== 1'b0 || bus_if.drop_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_status: ovf=%0b drop=%0d want 0/0", bus_if.overflow, bus_if.drop_cnt);
    end
    tests_run++;
    if (bus_if.trace_pc !== 32'd0 || bus_if.trace_addr !== 5'd0 || bus_if.trace_data !== 32'd0) begin
      fails++; $display("FAIL reset_head: pc=%h addr=%0d data=%h want zeros", bus_if.trace_pc, bus_if.trace_addr, bus_if.trace_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 5'd8, 32'h3000, 32'h1234, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus_if.trace_valid !== 1'b1 || bus_if.count !== 4'd1) begin
      fails++; $display("FAIL single_valid: valid=%0b count=%0d want 1/1", bus_if.trace_valid, bus_if.count);
    end
    tests_run++;
    if (bus_if.trace_pc !== 32'h3000 || bus_if.trace_addr !== 5'd8 || bus_if.trace_data !== 32'h1234) begin
      fails++; $display("FAIL single_head: pc=%h addr=%0d data=%h want 3000/8/1234", bus_if.trace_pc, bus_if.trace_addr, bus_if.trace_data);
    end
    tick();
    tests_run++;
    if (bus_if.trace_data !== 32'h1234 || bus_if.trace_valid !== 1'b1) begin
      fails++; $display("FAIL single_hold: valid=%0b data=%h want 1/1234", bus_if.trace_valid, bus_if.trace_data);
    end
    bus_if.trace_ready = 1'b1;
    tick();
    bus_if.trace_ready = 1'b0;
    tests_run++;
    if (bus_if.trace_valid !== 1'b0 || bus_if.count !== 4'd0 || bus_if.trace_data !== 32'd0) begin
      fails++; $display("FAIL single_pop: valid=%0b count=%0d data=%h want 0/0/0", bus_if.trace_valid, bus_if.count, bus_if.trace_data);
    end
  endtask

  task automatic test_zero_filter();
    drive(1'b1, 5'd0, 32'h4000, 32'hFFFF, 1'b0, 1'b0);
    repeat (5) tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus_if.count !== 4'd0 || bus_if.trace_valid !== 1'b0 || bus_if.drop_cnt !== 16'd0) begin
      fails++; $display("FAIL zero_filter: count=%0d valid=%0b drop=%0d want 0/0/0", bus_if.count, bus_if.trace_valid, bus_if.drop_cnt);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 5'(i), 32'h5000 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus_if.count !== 4'd8 || bus_if.overflow !== 1'b1 || bus_if.drop_cnt !== 16'd2) begin
      fails++; $display("FAIL overflow_status: count=%0d ovf=%0b drop=%0d want 8/1/2", bus_if.count, bus_if.overflow, bus_if.drop_cnt);
    end
    bus_if.trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (bus_if.trace_valid !== 1'b1 || bus_if.trace_data !== 32'(i)) begin
        fails++; $display("FAIL overflow_drain[%0d]: valid=%0b data=%0d want 1/%0d", i, bus_if.trace_valid, bus_if.trace_data, i);
      end
      tick();
    end
    bus_if.trace_ready = 1'b0;
    tests_run++;
    if (bus_if.trace_valid !== 1'b0 || bus_if.count !== 4'd0 || bus_if.overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_empty: valid=%0b count=%0d ovf=%0b want 0/0/1", bus_if.trace_valid, bus_if.count, bus_if.overflow);
    end
  endtask

  task automatic test_clr_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd3, 32'h6000, 32'(100 + i), 1'b0, 1'b0);
      tick();
    end
    tests_run++;
    if (bus_if.count !== 4'd5 || bus_if.overflow !== 1'b1) begin
      fails++; $display("FAIL clr_setup: count=%0d ovf=%0b want 5/1", bus_if.count, bus_if.overflow);
    end
    drive(1'b1, 5'd3, 32'h6100, 32'hDEAD, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus_if.count !== 4'd0 || bus_if.overflow !== 1'b0 || bus_if.drop_cnt !== 16'd0 || bus_if.trace_valid !== 1'b0) begin
      fails++; $display("FAIL clr: count=%0d ovf=%0b drop=%0d valid=%0b want 0/0/0/0", bus_if.count, bus_if.overflow, bus_if.drop_cnt, bus_if.trace_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 32'h7000, 32'(200 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus_if.count !== 4'd3 || bus_if.trace_data !== 32'd200) begin
      fails++; $display("FAIL refill: count=%0d data=%0d want 3/200", bus_if.count, bus_if.trace_data);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (bus_if.trace_valid !== 1'b0 || bus_if.count !== 4'd0 || bus_if.trace_data !== 32'd0) begin
      fails++; $display("FAIL async_reset: valid=%0b count=%0d data=%h want 0/0/0", bus_if.trace_valid, bus_if.count, bus_if.trace_data);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd4, 32'h8000 + 32'(i), 32'h10 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    tests_run++;
    if (bus_if.count !== 4'd8) begin
      fails++; $display("FAIL full_fill: count=%0d want 8", bus_if.count);
    end
    drive(1'b1, 5'd4, 32'h8100, 32'hAA, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (bus_if.count !== 4'd8 || bus_if.drop_cnt !== 16'd0 || bus_if.trace_data !== 32'h11) begin
      fails++; $display("FAIL full_pushpop: count=%0d drop=%0d head=%h want 8/0/11", bus_if.count, bus_if.drop_cnt, bus_if.trace_data);
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] want;
      want = (i == 8) ? 32'hAA : 32'h10 + 32'(i);
      tests_run++;
      if (bus_if.trace_valid !== 1'b1 || bus_if.trace_data !== want) begin
        fails++; $display("FAIL full_drain[%0d]: valid=%0b data=%h want 1/%h", i, bus_if.trace_valid, bus_if.trace_data, want);
      end
      tick();
    end
    bus_if.trace_ready = 1'b0;
    tests_run++;
    if (bus_if.trace_valid !== 1'b0) begin
      fails++; $display("FAIL full_empty: valid=%0b want 0", bus_if.trace_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd17, 32'h9000 + 32'(i * 4), 32'(i), 1'b1, 1'b0);
      tick();
      tests_run++;
      if (bus_if.count > 4'd1 || bus_if.trace_valid !== 1'b1 || bus_if.trace_data !== 32'(i)) begin
        fails++; $display("FAIL stream[%0d]: count=%0d valid=%0b data=%0d want <=1/1/%0d", i, bus_if.count, bus_if.trace_valid, bus_if.trace_data, i);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (bus_if.trace_valid !== 1'b0 || bus_if.drop_cnt !== 16'd0) begin
      fails++; $display("FAIL stream_end: valid=%0b drop=%0d want 0/0", bus_if.trace_valid, bus_if.drop_cnt);
    end
    bus_if.trace_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 150) == 0));
      tick();
      tests_run++;
      if (bus_if.trace_valid !== (mq.size() > 0) || bus_if.count !== CW'(mq.size()) ||
          bus_if.trace_data !== exp_data() || bus_if.trace_pc !== exp_pc() ||
          bus_if.trace_addr !== exp_addr() || bus_if.overflow !== m_ovf ||
          bus_if.drop_cnt !== 16'(m_drop)) begin
        fails++;
        if (bad < 10)
          $display("FAIL random[%0d]: valid=%0b cnt=%0d pc=%h a=%0d d=%h ovf=%0b drop=%0d want %0b/%0d/%h/%0d/%h/%0b/%0d",
                   n, bus_if.trace_valid, bus_if.count, bus_if.trace_pc, bus_if.trace_addr, bus_if.trace_data,
                   bus_if.overflow, bus_if.drop_cnt, (mq.size() > 0), mq.size(), exp_pc(), exp_addr(),
                   exp_data(), m_ovf, m_drop);
        bad++;
      end
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    reset     = 1'b0;
    model_reset();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_zero_filter();
    test_overflow();
    test_clr_reset();
    test_full_pushpop();
    test_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Write-back trace buffer for the pipelined MIPS core. Captures every register-file write retired in the W stage (PC, destination register, data), buffers it in a show-ahead FIFO, and hands it to the simulation checker or trace port over a valid/ready handshake. It is the consuming end of the core's write-back stream. It lets the bench compare architectural results cycle-independently, whatever stalls or forwarding occur.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- CW, 4: width of `count`, equal to log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_en  in  1  W-stage register-file write enable.
- wb_pc  in  32  PC of the retiring instruction.
- wb_addr  in  5  destination register number.
- wb_data  in  32  value written.
- clr  in  1  synchronous clear of FIFO contents and error state.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts the head entry.
- trace_pc  out  32  head entry PC.
- trace_addr  out  5  head entry register number.
- trace_data  out  32  head entry data.
- count  out  CW  entries currently stored, 0..DEPTH.
- overflow  out  1  sticky flag: at least one event was dropped.
- drop_cnt  out  16  number of dropped events, saturating.

## Operation
- Capture condition: `wb_en`=1 and `wb_addr`≠0. Writes to $0 are never recorded.
- Storage: circular buffer of DEPTH × 69-bit entries {pc, addr, data}.
  - Write pointer and read pointer wrap modulo DEPTH.
  - `count` is maintained as a separate register. full = (count==DEPTH), empty = (count==0).
- Pop: occurs when `trace_valid`=1 and `trace_ready`=1 at a rising edge. The read pointer advances and `count` decrements.
- Push decision, evaluated at each edge when the capture condition holds:
  - not full → push.
  - full and pop in the same edge → push. Count stays DEPTH, both pointers advance.
  - full and no pop → event dropped. `overflow` is set to 1. `drop_cnt` increments, saturating at 16'hFFFF.
- Push and pop in the same edge while not full: both performed, `count` unchanged.
- Empty with a push: no bypass. The entry becomes visible the following cycle.
- Output format: show-ahead, driven from the head entry.
  - When empty: `trace_valid`=0 and `trace_pc`/`trace_addr`/`trace_data` = 0.
- `trace_valid` does not depend combinationally on `trace_ready`. Head outputs remain stable while valid=1 and ready=0.
- `clr`=1 at an edge has priority over push and pop:
  - pointers, `count`, `overflow` and `drop_cnt` are set to 0;
  - any event presented in that cycle is discarded and is not counted as a drop.
- Reset (`reset`=0), asynchronous:
  - `trace_valid`=0, `trace_pc`/`trace_addr`/`trace_data`=0, `count`=0, `overflow`=0, `drop_cnt`=0;
  - pointers = 0.
  - Storage contents need not be cleared.
  - Reset mid-stream discards all pending entries.
  - Deassertion is sampled by the first rising edge after `reset` returns to 1.

## Timing
- Capture latency: an event sampled at edge N is visible at `trace_*` with `trace_valid`=1 from just after edge N, if the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained indefinitely with no drops when `trace_ready` is held at 1.
- `count`, `overflow` and `drop_cnt` are registered and update at the same edge as the push/pop/drop they reflect.
- Entries are popped strictly in capture order. Dropped events create no gap marker; only `drop_cnt` records them.

## Test plan
- Reset then single event: `reset` low for 3 cycles, then high. Drive wb_en=1, addr=8, pc=0x3000, data=0x1234 for one cycle with `trace_ready`=0.
  - Next cycle: valid=1, trace_pc=0x3000, trace_addr=8, trace_data=0x1234, count=1.
  - Then raise ready for one cycle → valid=0, count=0.
- $0 filter: drive wb_en=1, addr=0, data=0xFFFF for 5 cycles → count stays 0, valid=0, drop_cnt=0.
- Overflow (DEPTH=8): push 10 events with data=1..10 and ready=0.
  - Result: count=8, overflow=1, drop_cnt=2.
  - Then drain with ready=1 → outputs data 1..8 in order, then valid=0.
- Full with simultaneous push/pop: fill to 8, then push data=0xAA with ready=1 in the same cycle.
  - Result: count stays 8, drop_cnt unchanged.
  - The popped entry is the oldest; 0xAA appears last in the drain.
- Streaming and wrap: ready=1, push 20 consecutive events (data=0..19).
  - count ≤ 1 throughout.
  - Output sequence 0..19 with no drops, exercising pointer wrap twice.
- Clear and async reset: with count=5 and overflow=1, pulse clr together with a push → count=0, overflow=0, drop_cnt=0, valid=0.
  - Refill to 3, then assert `reset` low between edges → valid and count go to 0 immediately, with no clock edge required.
